tt_um_alvin_asmar_tff_cmd: RTL and testbench

Pin-level command responder for the toggle-flip-flop tile. The host, either a cocotb bench or an external MCU, drives the project pins and this block answers over them. Eight T flip-flops are controlled over a 4-phase strobe/ack handshake on the TinyTapeout pin set. The block also keeps an 8-bit change counter that the host can read back on `uo_out`.

---
 rtl/tt_tff_cmd_pkg.sv | 22 ++
 rtl/tt_sync2.sv | 29 ++
 rtl/tt_um_alvin_asmar_tff_cmd.sv | 115 +++++++++++
 tb/tb_tt_um_alvin_asmar_tff_cmd.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_tff_cmd_pkg.sv
// Shared types and constants for the toggle-flip-flop command responder.
//   op_t    : host opcode carried on uio_in[2:1]
//   state_t : command FSM state
//   UIO_OE_C: fixed bidirectional-pin direction mask (ack and busy are outputs)
package tt_tff_cmd_pkg;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_LOAD   = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_READ   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_ACK  = 2'b10
  } state_t;

  localparam logic [7:0] UIO_OE_C = 8'hC0;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for signals that are asynchronous to clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input bits
//   q     : synchronized output, two clk edges after d is sampled
module tt_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_um_alvin_asmar_tff_cmd.sv
// Pin-level command responder for a bank of eight T flip-flops.
// The host runs a 4-phase strobe/ack handshake on the TinyTapeout pins.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ena        : tile selected; new commands are accepted only while high
//   ui_in      : command data byte
//   uio_in     : [0] strobe (asynchronous), [2:1] opcode, [7:3] unused
//   uo_out     : flip-flop bank q, or the change counter while acking a READ
//   uio_out    : [7] ack, [6] busy, [5:0] zero
//   uio_oe     : constant 8'hC0
module tt_um_alvin_asmar_tff_cmd #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tt_tff_cmd_pkg::*;

  state_t           state;
  op_t              op_r;
  logic [7:0]       data_r;
  logic [7:0]       q;
  logic [7:0]       q_next;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             ack;
  logic             busy;
  logic             strobe_s;
  logic             valid_s;
  logic             unused_uio;

  // A constant 1 travels through the synchronizer next to strobe. It reaches
  // valid_s only once strobe_s holds a real pin sample rather than the reset
  // value, so a strobe held high across reset release never looks "low".
  tt_sync2 #(.W(2)) u_sync_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({1'b1, uio_in[0]}),
    .q     ({valid_s, strobe_s})
  );

  // NOTE: every variable driven here gets a default first so no latch is
  // inferred for the unlisted opcode paths.
  always_comb begin
    q_next = q;
    case (op_r)
      OP_TOGGLE: q_next = q ^ data_r;
      OP_LOAD:   q_next = data_r;
      OP_CLEAR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_r   <= OP_TOGGLE;
      data_r <= '0;
      q      <= '0;
      cnt    <= '0;
      armed  <= 1'b0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      uo_out <= '0;
    end else begin
      if (valid_s && !strobe_s) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (strobe_s && armed && ena) begin
            state  <= S_EXEC;
            busy   <= 1'b1;
            op_r   <= op_t'(uio_in[2:1]);
            data_r <= ui_in;
          end
        end

        S_EXEC: begin
          q     <= q_next;
          if (q_next != q) cnt <= cnt + CNT_W'(1);
          state <= S_ACK;
          ack   <= 1'b1;
          // READ never changes cnt, so the pre-edge value is the one to show.
          uo_out <= (op_r == OP_READ) ? cnt : q_next;
        end

        S_ACK: begin
          if (!strobe_s) begin
            state  <= S_IDLE;
            ack    <= 1'b0;
            busy   <= 1'b0;
            uo_out <= q;
          end
        end

        default: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uio_out    = {ack, busy, 6'b0};
  assign uio_oe     = UIO_OE_C;
  assign unused_uio = ^uio_in[7:3];

endmodule

// File: tb/tb_tt_um_alvin_asmar_tff_cmd.sv
// Self-checking bench: a behavioural model (q, cnt updated by the opcode
// rules) predicts every observed value; randomized commands exercise it.
module tb_tt_um_alvin_asmar_tff_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int passed = 0;
  int total  = 0;

  // reference model state
  logic [7:0] m_q;
  logic [7:0] m_cnt;

  tt_um_alvin_asmar_tff_cmd #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %02h expected %02h", name, got, exp);
    else passed++;
  endtask

  // Model of one command: returns what uo_out shows during ack.
  function automatic logic [7:0] model_apply(input logic [1:0] op, input logic [7:0] data);
    logic [7:0] nq;
    case (op)
      2'd0: nq = m_q ^ data;
      2'd1: nq = data;
      2'd2: nq = 8'h00;
      default: nq = m_q;
    endcase
    if (op == 2'd3) return m_cnt;
    if (nq != m_q) m_cnt = m_cnt + 8'd1;
    m_q = nq;
    return m_q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_q = 8'h00;
    m_cnt = 8'h00;
    // let the strobe synchronizer fill with real samples and arm
    repeat (4) @(negedge clk);
  endtask

  // Full handshake with checks. Called at a negedge with strobe low.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] data,
                         input bit drop_ena, input bit check_lat);
    int edges;
    logic [7:0] exp_ack;
    ui_in = data;
    uio_in = {5'b0, op, 1'b1};
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (!uio_out[7] && edges < 20);
    if (!uio_out[7]) begin
      total++;
      $display("FAIL %s ack timeout: got ack=0 expected ack=1", name);
      uio_in[0] = 1'b0;
      repeat (6) @(negedge clk);
      return;
    end
    if (check_lat) chk({name, " accept latency"}, 8'(edges), 8'd4);
    exp_ack = model_apply(op, data);
    chk({name, " uo_out during ack"}, uo_out, exp_ack);
    chk({name, " busy during ack"}, {7'b0, uio_out[6]}, 8'h01);
    if (drop_ena) ena = 1'b0;
    ui_in = $urandom;
    uio_in = 8'h00;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (uio_out[7] && edges < 20);
    // strobe low sampled at F0, ack falls on F2: three edges after the drop
    if (check_lat) chk({name, " release latency"}, 8'(edges), 8'd3);
    chk({name, " uio_out idle"}, uio_out, 8'h00);
    chk({name, " q after release"}, uo_out, m_q);
    ena = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'hC0);
    do_reset();
    chk("post-reset uo_out", uo_out, 8'h00);
    chk("post-reset uio_out", uio_out, 8'h00);
  endtask

  task automatic test_directed();
    run_cmd("load a5", 2'd1, 8'hA5, 1'b0, 1'b1);
    run_cmd("read cnt1", 2'd3, 8'h00, 1'b0, 1'b0);
    run_cmd("toggle ff", 2'd0, 8'hFF, 1'b0, 1'b0);
    chk("q after toggle ff", uo_out, 8'h5A);
    run_cmd("toggle 00", 2'd0, 8'h00, 1'b0, 1'b0);
    run_cmd("read cnt2", 2'd3, 8'h3C, 1'b0, 1'b0);
    chk("model cnt is 2", m_cnt, 8'h02);
    run_cmd("clear", 2'd2, 8'hFF, 1'b0, 1'b1);
    run_cmd("clear again", 2'd2, 8'hFF, 1'b0, 1'b0);
    run_cmd("read cnt3", 2'd3, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (255) run_cmd("wrap step", 2'd0, 8'h01, 1'b0, 1'b0);
    run_cmd("read cnt ff", 2'd3, 8'h00, 1'b0, 1'b0);
    run_cmd("wrap last", 2'd0, 8'h01, 1'b0, 1'b0);
    run_cmd("read cnt wrapped", 2'd3, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_strobe_through_reset();
    bit seen;
    @(negedge clk);
    ui_in = 8'h3C;
    uio_in = 8'h03;          // LOAD with strobe high
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_q = 8'h00;
    m_cnt = 8'h00;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (uio_out[7] || uio_out[6]) seen = 1'b1;
    end
    chk("held strobe ignored", {7'b0, seen}, 8'h00);
    chk("held strobe q", uo_out, 8'h00);
    uio_in = 8'h00;
    repeat (4) @(negedge clk);
    run_cmd("after rearm", 2'd1, 8'h3C, 1'b0, 1'b1);
  endtask

  task automatic test_ena();
    bit seen;
    ena = 1'b0;
    ui_in = 8'hFF;
    uio_in = 8'h01;          // TOGGLE FF
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (uio_out[7]) seen = 1'b1;
    end
    uio_in = 8'h00;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    chk("ena low no ack", {7'b0, seen}, 8'h00);
    chk("ena low q kept", uo_out, m_q);
    run_cmd("ena drop in ack", 2'd0, 8'h81, 1'b1, 1'b1);
  endtask

  task automatic test_reset_in_exec();
    int n;
    ui_in = 8'h77;
    uio_in = 8'h03;          // LOAD 77
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!uio_out[6] && n < 20);
    chk("reached exec", {7'b0, uio_out[6]}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("rst exec uio_out", uio_out, 8'h00);
    chk("rst exec uo_out", uo_out, 8'h00);
    chk("rst exec uio_oe", uio_oe, 8'hC0);
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    m_q = 8'h00;
    m_cnt = 8'h00;
    repeat (4) @(negedge clk);
    run_cmd("read after rst", 2'd3, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      run_cmd("random", op, d, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    m_q = 8'h00;
    m_cnt = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_wrap();
    test_strobe_through_reset();
    test_ena();
    test_reset_in_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
